// File: rtl/r2sdf_first_stage_if.sv
// Sample-in / butterfly-out bundle between the sample source, the first R2SDF
// stage and its downstream CORDIC.
interface r2sdf_first_stage_if;
   logic               iValid;
   logic signed [20:0] iData;
   logic               oValid;
   logic signed [21:0] oReal;
   logic        [5:0]  oPhi;
   logic               oSof;

   modport master (
      output iValid, iData,
      input  oValid, oReal, oPhi, oSof
   );

   modport slave (
      input  iValid, iData,
      output oValid, oReal, oPhi, oSof
   );
endinterface

// File: rtl/r2sdf_first_stage.sv
// First radix-2 single-path delay-feedback stage of a 64-point FFT on real input:
// 32-deep feedback delay line, sums out in the second half, differences one frame later.
module r2sdf_first_stage (
   input  logic              iClk,
   input  logic              iRst,
   r2sdf_first_stage_if.slave bus
);
   localparam int D = 32;

   logic        [5:0]  cntReg,  cntNext;
   logic               primedReg, primedNext;
   logic signed [21:0] dlReg  [0:D-1];
   logic signed [21:0] dlNext [0:D-1];

   logic signed [21:0] oRealReg, oRealNext;
   logic        [5:0]  oPhiReg,  oPhiNext;
   logic               oValidReg, oValidNext;
   logic               oSofReg,   oSofNext;

   logic signed [21:0] dlOut;
   logic signed [21:0] sExt;
   logic signed [21:0] shiftIn;
   logic               secondHalf;

   assign dlOut      = dlReg[D-1];
   assign sExt       = {bus.iData[20], bus.iData};
   assign secondHalf = cntReg[5];

   // Second half feeds back x[n]-x[n+32]; those differences surface during the next frame.
   assign shiftIn = secondHalf ? (dlOut - sExt) : sExt;

   genvar gi;
   generate
      for (gi = 0; gi < D; gi++) begin : gDelay
         if (gi == 0) begin : gHead
            assign dlNext[gi] = bus.iValid ? shiftIn : dlReg[gi];
         end else begin : gBody
            assign dlNext[gi] = bus.iValid ? dlReg[gi-1] : dlReg[gi];
         end
      end
   endgenerate

   always_comb begin
      cntNext    = cntReg;
      primedNext = primedReg;
      oRealNext  = oRealReg;
      oPhiNext   = oPhiReg;
      oValidNext = 1'b0;
      oSofNext   = 1'b0;
      if (bus.iValid) begin
         cntNext    = cntReg + 6'd1;
         primedNext = primedReg | (cntReg == 6'd63);
         if (secondHalf) begin
            oRealNext  = dlOut + sExt;
            oPhiNext   = 6'd0;
            oValidNext = 1'b1;
            oSofNext   = (cntReg == 6'd32);
         end else begin
            oRealNext  = dlOut;
            oPhiNext   = {1'b0, cntReg[4:0]};
            oValidNext = primedReg;
         end
      end
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         cntReg    <= 6'd0;
         primedReg <= 1'b0;
         oRealReg  <= 22'sd0;
         oPhiReg   <= 6'd0;
         oValidReg <= 1'b0;
         oSofReg   <= 1'b0;
         for (int i = 0; i < D; i++) begin
            dlReg[i] <= 22'sd0;
         end
      end else begin
         cntReg    <= cntNext;
         primedReg <= primedNext;
         oRealReg  <= oRealNext;
         oPhiReg   <= oPhiNext;
         oValidReg <= oValidNext;
         oSofReg   <= oSofNext;
         for (int i = 0; i < D; i++) begin
            dlReg[i] <= dlNext[i];
         end
      end
   end

   assign bus.oReal  = oRealReg;
   assign bus.oPhi   = oPhiReg;
   assign bus.oValid = oValidReg;
   assign bus.oSof   = oSofReg;
endmodule

// File: doc/r2sdf_first_stage.md
R2SDF_FIRST_STAGE -- requirements
Module: r2sdf_first_stage

Interface
REQ-001 The block SHALL have no parameters; the FFT size is fixed at N=64, with a delay depth D=32.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset: iClk input 1, the rising-edge clock.
REQ-003 iRst input 1: asynchronous active-high reset.
REQ-004 iValid input 1: iData carries a sample this cycle.
REQ-005 iData input 21: signed two's-complement real sample, in natural order; the imaginary part is implicitly 0.
REQ-006 oValid output 1: oReal/oPhi are valid this cycle.
REQ-007 oReal output 22: signed butterfly result, feeding the first-stage CORDIC iReal.
REQ-008 oPhi output 6: unsigned twiddle index k (0..31), feeding the first-stage CORDIC iPhi; 0 means no rotation.
REQ-009 oSof output 1: pulses with the first sum output (k=0) of each frame.

Function
REQ-010 The block SHALL hold a 6-bit sample counter cnt and advance it by 1 (mod 64) only on cycles with iValid=1.
REQ-011 It SHALL hold a 32-entry x 22-bit shift register dl, whose tail is dl_out, shifting only on iValid=1.
REQ-012 It SHALL define s = iData sign-extended to 22 bits.
REQ-013 First-half sample (iValid=1, cnt[5]=0): shift s into dl; at the next edge oReal<=dl_out, oPhi<={0,cnt[4:0]}, oValid<=primed, oSof<=0.
REQ-014 Second-half sample (iValid=1, cnt[5]=1): shift dl_out-s into dl; at the next edge oReal<=dl_out+s, oPhi<=0, oValid<=1, oSof<=(cnt==32).
REQ-015 Arithmetic SHALL be 22-bit two's complement; with 21-bit inputs the sum and difference never overflow, so no saturation is required.
REQ-016 primed SHALL be set at the edge where cnt wraps 63->0 with iValid=1, and SHALL remain set until reset.
REQ-017 While primed=0, the first-half outputs of the first frame SHALL have oValid=0.
REQ-018 The latency SHALL be exactly 1 clock from an accepted sample to its registered output.
REQ-019 Outputs SHALL be produced in this order: sums X0 for n=0..31 during the second half, then differences (x[n]-x[n+32]) with oPhi=n during the next frame's first half.
REQ-020 iValid=0 SHALL freeze cnt, dl and primed, drive oValid<=0 and oSof<=0, and leave oReal/oPhi holding their last values.
REQ-021 Arbitrary gaps in iValid SHALL NOT change the data results.
REQ-022 The block SHALL have no backpressure; the downstream stage accepts every cycle with oValid=1.
REQ-023 The final frame's differences SHALL be emitted only when the next frame's samples are supplied; there is no automatic flush.

Reset
REQ-024 While iRst=1, the block SHALL immediately force cnt=0, primed=0, every dl entry=0, oReal=0, oPhi=0, oValid=0 and oSof=0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame.
REQ-026 After reset releases, the next accepted sample SHALL be treated as n=0 of a new first frame, with primed=0.

Verification
REQ-027 Constant frame: 64 samples of 100 with iValid held high, followed by 32 more samples.
- Required: no oValid for the first 32 cycles.
- Then 32 outputs of 200 with oPhi=0, and oSof on the first of them.
- Then 32 outputs of 0 with oPhi=0..31.
REQ-028 Impulse: x[0]=1000, all other samples 0, two frames.
- Required: first sum=1000 (oPhi=0), remaining sums 0.
- Next frame: diff n=0 is 1000 with oPhi=0; other diffs are 0.
REQ-029 Extremes: x[n]=-1048576 for n<32 and x[n]=1048575 for n>=32.
- Required: sums=-1, diffs=-2097151.
- No wrap occurs in either result.
REQ-030 Gapped input: the REQ-027 stimulus with iValid toggling 1,0,1,0.
- Required: identical oReal/oPhi sequence.
- oValid is high only on the cycle after each accepted sample.
REQ-031 Reset mid-frame: assert iRst after sample 40 of frame 2, then replay the REQ-027 stimulus.
- Required: outputs are 0 and oValid=0 during reset.
- After release, the response exactly matches REQ-027, including the suppressed first half.
REQ-032 Continuous random streaming for 10 frames.
- The oReal/oPhi sequence SHALL match a bit-exact reference model of REQ-013..REQ-019.
- oSof SHALL occur once per frame, at cnt==32.
